// File: rtl/mem_access_ctrl_if.sv
// MEM-stage <-> SRAM controller bundle.
// master: pipeline + SRAM side; slave: mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       alu_res;
  logic [31:0]       rm_val;
  logic              ready;
  logic [31:0]       data_mem;
  logic              addr_err;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              sram_we;
  logic              sram_re;
  logic [31:0]       sram_rdata;

  modport master (
    output MEM_R_EN,
    output MEM_W_EN,
    output alu_res,
    output rm_val,
    output sram_rdata,
    input  ready,
    input  data_mem,
    input  addr_err,
    input  sram_addr,
    input  sram_wdata,
    input  sram_we,
    input  sram_re
  );

  modport slave (
    input  MEM_R_EN,
    input  MEM_W_EN,
    input  alu_res,
    input  rm_val,
    input  sram_rdata,
    output ready,
    output data_mem,
    output addr_err,
    output sram_addr,
    output sram_wdata,
    output sram_we,
    output sram_re
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a multi-cycle word SRAM.
// Ports: clk, rst (async high), bus (mem_access_ctrl_if.slave).
module mem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 5,
  parameter int          ADDR_W      = 16
) (
  input  logic clk,
  input  logic rst,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;

  logic              req;
  logic              wr_in;
  logic [31:0]       off;
  logic              bad;
  logic [ADDR_W-1:0] widx;

  logic              start;
  logic              fail;
  logic              finish;

  logic              is_st;
  logic [31:0]       data_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              re_q;

  assign req   = bus.MEM_R_EN | bus.MEM_W_EN;
  assign wr_in = bus.MEM_W_EN;

  // Addresses below BASE_ADDR wrap to huge offsets
  // and fall out of range with no separate compare.
  assign off  = bus.alu_res - BASE_ADDR;
  assign widx = off[ADDR_W+1:2];
  assign bad  = (|off[1:0]) | (|off[31:ADDR_W+2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    start   = 1'b0;
    fail    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad) begin
            fail    = 1'b1;
            state_d = DONE;
          end else begin
            start   = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == CNT_LAST) begin
          finish  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered: raised on the edge into
  // ACCESS, dropped on the edge into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_st   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      err_q <= fail;
      if (start) begin
        is_st   <= wr_in;
        addr_q  <= widx;
        wdata_q <= bus.rm_val;
        we_q    <= wr_in;
        re_q    <= ~wr_in;
      end
      if (finish) begin
        we_q   <= 1'b0;
        re_q   <= 1'b0;
        data_q <= is_st ? 32'd0 : bus.sram_rdata;
      end
      if (fail) begin
        data_q <= '0;
      end
    end
  end

  assign bus.ready      = (state == DONE) |
                          ((state == IDLE) & ~req);
  assign bus.data_mem   = data_q;
  assign bus.addr_err   = err_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_re    = re_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl.
// Small word-SRAM model, hand-computed expectations.
module tb_mem_access_ctrl;

  logic clk;
  logic rst;

  mem_access_ctrl_if #(.ADDR_W(16)) bus ();

  mem_access_ctrl #(
    .BASE_ADDR   (32'd1024),
    .WAIT_CYCLES (5),
    .ADDR_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (bus.sram_we)
      mem[bus.sram_addr[7:0]] <= bus.sram_wdata;
  end

  assign bus.sram_rdata = mem[bus.sram_addr[7:0]];

  int n_chk;
  int n_pass;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  int          lat;
  int          we_n;
  int          re_n;
  logic [15:0] seen_addr;
  logic [31:0] seen_wd;
  logic [31:0] dm;
  logic        ae;
  logic        strb_done;

  task automatic do_acc(
    input logic        w,
    input logic        r,
    input logic [31:0] a,
    input logic [31:0] d
  );
    logic ok;
    @(posedge clk); #1;
    bus.MEM_W_EN = w;
    bus.MEM_R_EN = r;
    bus.alu_res  = a;
    bus.rm_val   = d;
    #1;
    lat = 0; we_n = 0; re_n = 0;
    seen_addr = '0; seen_wd = '0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sram_we) begin
        we_n++;
        seen_addr = bus.sram_addr;
        seen_wd   = bus.sram_wdata;
      end
      if (bus.sram_re) begin
        re_n++;
        seen_addr = bus.sram_addr;
      end
      if (bus.ready) begin
        ok = 1'b1;
        break;
      end
      lat++;
      @(posedge clk); #2;
    end
    if (!ok) check("timeout", 32'd0, 32'd1);
    dm        = bus.data_mem;
    ae        = bus.addr_err;
    strb_done = bus.sram_we | bus.sram_re;
  endtask

  task automatic idle_cyc();
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b0;
    bus.MEM_R_EN = 1'b0;
    #1;
  endtask

  task automatic chk_ok(
    input string       tag,
    input int          e_we,
    input int          e_re,
    input logic [15:0] e_addr,
    input logic [31:0] e_dm
  );
    check({tag, "_lat"},  32'(lat),  32'd6);
    check({tag, "_we"},   32'(we_n), 32'(e_we));
    check({tag, "_re"},   32'(re_n), 32'(e_re));
    check({tag, "_addr"}, 32'(seen_addr), 32'(e_addr));
    check({tag, "_dm"},   dm, e_dm);
    check({tag, "_err"},  32'(ae), 32'd0);
    check({tag, "_sdn"},  32'(strb_done), 32'd0);
  endtask

  task automatic chk_err(input string tag);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_stb"}, 32'(we_n + re_n), 32'd0);
    check({tag, "_err"}, 32'(ae), 32'd1);
    check({tag, "_dm"},  dm, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.MEM_W_EN = 1'b0;
    bus.MEM_R_EN = 1'b0;
    bus.alu_res  = '0;
    bus.rm_val   = '0;
    #2;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_dm",    bus.data_mem, 32'd0);
    check("rst_err",   32'(bus.addr_err), 32'd0);
    check("rst_we",    32'(bus.sram_we), 32'd0);
    check("rst_re",    32'(bus.sram_re), 32'd0);
    check("rst_addr",  32'(bus.sram_addr), 32'd0);
    check("rst_wd",    bus.sram_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a store
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b1;
    bus.alu_res  = 32'd1032;
    bus.rm_val   = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #2;
    check("mid_cnt", 32'(dut.cnt), 32'd2);
    check("mid_we",  32'(bus.sram_we), 32'd1);
    rst = 1'b1;
    bus.MEM_W_EN = 1'b0;
    #1;
    check("mid_rst_we",  32'(bus.sram_we), 32'd0);
    check("mid_rst_st",  32'(dut.state), 32'd0);
    check("mid_rst_rdy", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    do_acc(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
    chk_ok("st1028", 5, 0, 16'd1, 32'd0);
    check("st1028_wd", seen_wd, 32'hDEAD_BEEF);

    do_acc(1'b0, 1'b1, 32'd1028, 32'h0);
    chk_ok("ld1028", 0, 5, 16'd1, 32'hDEAD_BEEF);

    do_acc(1'b0, 1'b1, 32'd1000, 32'h0);
    chk_err("ld1000");
    idle_cyc();
    check("err_pulse", 32'(bus.addr_err), 32'd0);
    check("idle_rdy",  32'(bus.ready), 32'd1);

    do_acc(1'b0, 1'b1, 32'd1028, 32'h0);
    chk_ok("ld_b", 0, 5, 16'd1, 32'hDEAD_BEEF);
    do_acc(1'b0, 1'b1, 32'd1025, 32'h0);
    chk_err("ld1025");

    do_acc(1'b0, 1'b1, 32'd1028, 32'h0);
    chk_ok("ld_c", 0, 5, 16'd1, 32'hDEAD_BEEF);
    do_acc(1'b1, 1'b1, 32'd1024, 32'h1234_5678);
    chk_ok("both", 5, 0, 16'd0, 32'd0);
    check("both_wd", seen_wd, 32'h1234_5678);

    do_acc(1'b1, 1'b0, 32'd263164, 32'h5A5A_A5A5);
    chk_ok("top", 5, 0, 16'hFFFF, 32'd0);
    do_acc(1'b1, 1'b0, 32'd263168, 32'h0);
    chk_err("over");

    do_acc(1'b1, 1'b0, 32'd1036, 32'hCAFE_F00D);
    chk_ok("b2b_st", 5, 0, 16'd3, 32'd0);
    do_acc(1'b0, 1'b1, 32'd1036, 32'h0);
    chk_ok("b2b_ld", 0, 5, 16'd3, 32'hCAFE_F00D);
    do_acc(1'b0, 1'b1, 32'd1024, 32'h0);
    chk_ok("ld1024", 0, 5, 16'd0, 32'h1234_5678);

    idle_cyc();
    check("end_rdy", 32'(bus.ready), 32'd1);
    check("end_dm",  bus.data_mem, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
